lamp_display_ctrl: RTL



---
 rtl/lamp_display_pkg.sv | 32 +++
 rtl/lamp_display_ctrl_hex7seg.sv | 12 +
 rtl/lamp_display_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lamp_display_pkg.sv
// Shared types and glyph constants for the six-digit lamp bank.
// Segment patterns are active-low, bit0=a .. bit6=g.
package lamp_display_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_W      = 7;

  typedef enum logic [1:0] {
    IDLE,
    SHOW_CALC,
    SHOW_STAT
  } state_e;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_R     = 7'h2F;

  localparam logic [SEG_W-1:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic                    neg;
    logic                    blz;
  } calc_req_t;

endpackage

// File: rtl/lamp_display_ctrl_hex7seg.sv
// Nibble to active-low 7-segment glyph.
// Pure lookup into the shared glyph table.
module hex7seg
  import lamp_display_pkg::*;
(
  input  logic [3:0]       nib,
  output logic [SEG_W-1:0] seg
);

  assign seg = HEX_GLYPH[nib];

endmodule

// File: rtl/lamp_display_ctrl.sv
// Lamp bank controller: arbitrates calc/status requests,
// formats digits and owns hold, blink and zero blanking.
module lamp_display_ctrl
  import lamp_display_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2,
  parameter int HOLD_MS  = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        calc_valid,
  output logic        calc_ready,
  input  logic [23:0] calc_value,
  input  logic        calc_neg,
  input  logic        stat_valid,
  output logic        stat_ready,
  input  logic [7:0]  stat_code,
  input  logic        blank_lz,
  output logic [41:0] lamps,
  output logic        busy
);

  localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);
  localparam int HOLD_CYC = CLK_HZ / 1000 * HOLD_MS;
  localparam int HOLD_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int BLINK_W  = (HALF > 1) ? $clog2(HALF) : 1;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               phase_q, phase_d;
  calc_req_t          req_q, req_d;
  logic [7:0]         code_q, code_d;
  logic [41:0]        lamps_q, lamps_d;
  logic               calc_ready_q, calc_ready_d;
  logic               stat_ready_q, stat_ready_d;
  logic               busy_q, busy_d;

  logic               stat_acc, calc_acc, in_stat, lead;
  logic [3:0]         nib      [NUM_DIGITS];
  logic [SEG_W-1:0]   glyph    [NUM_DIGITS];
  logic [SEG_W-1:0]   calc_pat [NUM_DIGITS];

  assign calc_ready = calc_ready_q & ~stat_valid;
  assign stat_ready = stat_ready_q;
  assign lamps      = lamps_q;
  assign busy       = busy_q;

  // Low two digits carry the error code while status is shown
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    if (g < 2) begin : g_lo
      assign nib[g] = (state_q == SHOW_STAT) ?
                      code_q[4*g +: 4] : req_q.value[4*g +: 4];
    end else begin : g_hi
      assign nib[g] = req_q.value[4*g +: 4];
    end
    hex7seg u_hex (
      .nib (nib[g]),
      .seg (glyph[g])
    );
  end

  always_comb begin
    lead = req_q.blz;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      calc_pat[i] = glyph[i];
      if (i == NUM_DIGITS-1 && req_q.neg) begin
        calc_pat[i] = SEG_MINUS;
      end else if (lead && i != 0 && req_q.value[4*i +: 4] == 4'h0) begin
        calc_pat[i] = SEG_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    blink_d  = blink_q;
    phase_d  = phase_q;
    req_d    = req_q;
    code_d   = code_q;
    stat_acc = stat_valid & stat_ready_q;
    calc_acc = calc_valid & calc_ready;
    in_stat  = (state_q == SHOW_STAT) & ~stat_acc;
    unique case (1'b1)
      stat_acc: begin
        state_d = SHOW_STAT;
        hold_d  = HOLD_W'(HOLD_CYC - 1);
        blink_d = '0;
        phase_d = 1'b1;
        code_d  = stat_code;
      end
      calc_acc: begin
        state_d = SHOW_CALC;
        req_d   = '{value: calc_value, neg: calc_neg, blz: blank_lz};
      end
      in_stat: begin
        if (hold_q == '0) begin
          state_d = IDLE;
          blink_d = '0;
          phase_d = 1'b0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
          if (blink_q == BLINK_W'(HALF - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + BLINK_W'(1);
          end
        end
      end
      default: ;
    endcase
    calc_ready_d = (state_d != SHOW_STAT);
    stat_ready_d = 1'b1;
    busy_d       = (state_d == SHOW_STAT);
  end

  always_comb begin
    lamps_d = '1;
    unique case (state_q)
      SHOW_CALC: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          lamps_d[SEG_W*i +: SEG_W] = calc_pat[i];
        end
      end
      SHOW_STAT: begin
        if (phase_q) begin
          lamps_d = {SEG_E, SEG_R, SEG_R, SEG_BLANK, glyph[1], glyph[0]};
        end
      end
      default: lamps_d = '1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      blink_q      <= '0;
      phase_q      <= 1'b0;
      req_q        <= '0;
      code_q       <= '0;
      lamps_q      <= '1;
      calc_ready_q <= 1'b0;
      stat_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      blink_q      <= blink_d;
      phase_q      <= phase_d;
      req_q        <= req_d;
      code_q       <= code_d;
      lamps_q      <= lamps_d;
      calc_ready_q <= calc_ready_d;
      stat_ready_q <= stat_ready_d;
      busy_q       <= busy_d;
    end
  end

endmodule
